// File: rtl/apb_wait_slave.sv
// APB completer with a word-addressed register file, per-transfer wait states and PSLVERR.
// Optional byte-lane write strobes are enabled by defining APB_WAIT_SLAVE_PSTRB_EN.
module apb_wait_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_WAIT_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  input  logic [WAIT_W-1:0]   wait_cycles,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPAN  = DEPTH * BYTES;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [WAIT_W-1:0]   r_waitQ;
  logic [WAIT_W-1:0]   r_count;
  logic [IDX_W-1:0]    r_index;
  logic                r_err;
  logic                r_write;
  logic [DATA_W-1:0]   r_prdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_latch;
  logic                w_ready;
  logic                w_complete;
  logic                w_misaligned;
  logic                w_outOfRange;
  logic                w_addrErr;
  logic [IDX_W-1:0]    w_index;

  // Decode is computed on the SETUP address and frozen for the whole transfer.
  assign w_misaligned = (paddr & ADDR_W'(BYTES - 1)) != '0;
  assign w_outOfRange = {1'b0, paddr} >= (ADDR_W + 1)'(SPAN);
  assign w_addrErr    = w_misaligned | w_outOfRange;
  assign w_index      = paddr[OFF_W +: IDX_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // pready depends only on registered counter/wait values, never on bus inputs.
  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    w_ready     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_nextState = ACCESS;
          w_latch     = 1'b1;
        end
      end
      ACCESS: begin
        w_ready = (r_count == r_waitQ);
        if (!psel) begin
          w_nextState = IDLE;
        end else if (penable && w_ready) begin
          w_complete  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitQ  <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_prdata <= '0;
    end else if (w_latch) begin
      r_waitQ  <= wait_cycles;
      r_count  <= '0;
      r_index  <= w_index;
      r_err    <= w_addrErr;
      r_write  <= pwrite;
      r_prdata <= (!pwrite && !w_addrErr) ? r_mem[w_index] : '0;
    end else if (r_state == ACCESS) begin
      if (!psel || w_complete) begin
        r_prdata <= '0;
      end else if (penable && !w_ready) begin
        r_count <= r_count + WAIT_W'(1);
      end
    end
  end

  // Writes commit only on the completion edge of a decode-clean transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_complete && r_write && !r_err) begin
`ifdef APB_WAIT_SLAVE_PSTRB_EN
      for (int b = 0; b < BYTES; b++) begin
        if (pstrb[b]) begin
          r_mem[r_index][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
`else
      r_mem[r_index] <= pwdata;
`endif
    end
  end

  assign pready  = w_ready;
  assign pslverr = w_ready & r_err;
  assign prdata  = r_prdata;

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- Parametrised APB completer (slave) with an internal word-addressed register file, runtime-programmable wait states and error signalling.
- Successor to the fixed-width APB slave: generalised data/address width and depth; adds PSLVERR, per-transfer latched wait count and address-range checking.
- Sits on the APB bus behind the APB master; serves as a memory-mapped peripheral and as the reference completer for bus benches.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- ADDR_W, 12, byte address width of paddr.
- DEPTH, 16, number of DATA_W words in the register file; power of two, DEPTH*DATA_W/8 <= 2^ADDR_W.
- WAIT_W, 4, width of the wait_cycles input; maximum wait states is 2^WAIT_W-1.

Ports:
- clk  input  1  bus clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- psel  input  1  slave select.
- penable  input  1  access phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data; valid only while pready=1 on a read.
- pready  output  1  transfer complete.
- pslverr  output  1  transfer error; valid only while pready=1.
- wait_cycles  input  WAIT_W  wait states inserted into the next transfer; sampled in SETUP.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, wait counter=0, latched wait=0, prdata=0, pready=0, pslverr=0, all register-file words=0. Reset asserted mid-transfer aborts it; no write is committed.
- States: IDLE, ACCESS. SETUP is the cycle psel=1, penable=0 observed in IDLE.
- IDLE: on edge with psel=1 and penable=0 -> ACCESS; latch wait_cycles into wait_q, clear counter, latch address decode (index = paddr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)], err = paddr misaligned (low log2(DATA_W/8) bits nonzero) or paddr >= DEPTH*DATA_W/8). psel=1 with penable=1 in IDLE is a protocol error: ignored, stay IDLE.
- ACCESS: pready = (counter == wait_q), driven from registered state only (no combinational path from inputs). While psel=1 and penable=1 and pready=0: counter increments by 1 each cycle.
- Completion edge (ACCESS, psel=1, penable=1, pready=1): write with err=0 stores pwdata to mem[index]; read returns data; -> IDLE. Back-to-back: SETUP must follow in the next cycle; no pipelining.
- pslverr = pready & err. Errored write: no register update. Errored read: prdata = 0.
- prdata = mem[index] loaded on the IDLE->ACCESS edge for reads, held through ACCESS; 0 in IDLE and for writes.
- wait_cycles=0: pready high in the first ACCESS cycle (two-cycle transfer). Maximum: 2^WAIT_W-1 wait states; counter never wraps. wait_cycles changes during ACCESS do not affect the transfer in flight.
- psel deasserted in ACCESS before completion: abort, -> IDLE, no write, pready=0 next cycle.
- pwrite/paddr/pwdata are not re-checked in ACCESS; the master holds them stable per APB.

Optional Feature:
- Macro APB_WAIT_SLAVE_PSTRB_EN.
- Defined: extra input pstrb [DATA_W/8-1:0]. On a non-errored write completion, only byte lanes with pstrb[i]=1 are updated. A write with pstrb all-zero completes normally with no update. Reads ignore pstrb.
- Undefined: no pstrb port; writes update the full word.

Test Plan:
- Reset, wait_cycles=0, write 0xDEADBEEF to paddr 0x004 -> pready=1 in first ACCESS cycle, pslverr=0; read 0x004 -> prdata=0xDEADBEEF, transfer = 2 cycles.
- wait_cycles=5, write 0x12345678 to 0x008, then read -> pready low for exactly 5 ACCESS cycles, high on the 6th; readback 0x12345678.
- wait_cycles=3 latched, changed to 1 mid-ACCESS -> still 3 wait states; next transfer uses 1.
- Write 0xFFFFFFFF to 0x040 (DEPTH=16, out of range) and to 0x006 (misaligned) -> pready=1 with pslverr=1; all words unchanged; read 0x040 -> prdata=0, pslverr=1.
- wait_cycles=5, write 0xAAAA5555 to 0x00C, assert reset in 3rd ACCESS cycle -> pready/pslverr/prdata=0 immediately, state IDLE; read 0x00C -> 0x00000000.
- With APB_WAIT_SLAVE_PSTRB_EN: mem[0]=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> readback 0x11BB33DD.
